// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution engine:
// the frame-control state encoding and the accumulator width rule.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Full-precision width of a K*K sum of W x W products
  function automatic int acc_width(input int w, input int k);
    return 2 * w + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_stream_engine_if.sv
// Pixel-in / result-out valid-ready streams of the convolution engine.
// The engine takes the slave side; the producer/consumer takes the master side.
interface conv_stream_engine_if #(
  parameter int W = 8,
  parameter int K = 3
);
  import conv_pkg::*;

  localparam int ACC_W = acc_width(W, K);

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/conv_line_buffer.sv
// Enable-gated shift register delaying a pixel stream by DEPTH accepted
// samples; one instance holds one previous image row.
module conv_line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution over an NxN raster frame with stride S.
// Line buffers + sliding window feed a two-register multiply/sum pipeline.
module conv_stream_engine #(
  parameter int N      = 28,
  parameter int K      = 3,
  parameter int S      = 1,
  parameter int W      = 8,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               start,
  input  logic [K*K*W-1:0]   weights,
  output logic               frame_done,
  conv_stream_engine_if.slave bus
);
  import conv_pkg::*;

  localparam int ACC_W = acc_width(W, K);
  localparam int KK    = K * K;
  localparam int CNT_W = $clog2(N);
  localparam int PH_W  = (S > 1) ? $clog2(S) : 1;

  if (N < K || K < 2 || S < 1) begin : g_param_check
    $error("conv_stream_engine: requires N >= K >= 2 and S >= 1");
  end

  // Operands widened by one bit so one signed multiplier serves both modes
  function automatic logic signed [ACC_W-1:0] mul_ext(input logic [W-1:0] a,
                                                      input logic [W-1:0] b);
    logic signed [W:0]     ea;
    logic signed [W:0]     eb;
    logic signed [2*W+1:0] p;
    ea = (SIGNED != 0) ? {a[W-1], a} : {1'b0, a};
    eb = (SIGNED != 0) ? {b[W-1], b} : {1'b0, b};
    p  = (2*W+2)'(ea) * (2*W+2)'(eb);
    return ACC_W'(p);
  endfunction

  function automatic logic [PH_W-1:0] ph_step(input logic [PH_W-1:0] p);
    return (p == PH_W'(S - 1)) ? '0 : p + PH_W'(1);
  endfunction

  state_t                  state;
  logic [W-1:0]            w_q [KK];
  logic [CNT_W-1:0]        row, col;
  logic [PH_W-1:0]         row_ph, col_ph;
  logic [W-1:0]            lb_out [K-1];
  logic [W-1:0]            col_in [K];
  logic [W-1:0]            win_p0 [K][K];
  logic                    vld_p0;
  logic signed [ACC_W-1:0] prod_p1 [KK];
  logic                    vld_p1;
  logic signed [ACC_W-1:0] sum_c;
  logic [ACC_W-1:0]        sum_p2;
  logic                    vld_p2;
  logic                    adv, accept, emit, last_px;

  // Every stage freezes while a finished result waits for the consumer
  assign adv          = !(vld_p2 && !bus.out_ready);
  assign bus.in_ready = (state == ST_RUN) && adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_data  = sum_p2;
  assign bus.out_valid = vld_p2;

  // row_ph/col_ph hold (pos-K+1) mod S once the position reaches K-1
  assign emit    = (row >= CNT_W'(K - 1)) && (col >= CNT_W'(K - 1)) &&
                   (row_ph == '0) && (col_ph == '0);
  assign last_px = (row == CNT_W'(N - 1)) && (col == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      row_ph     <= '0;
      col_ph     <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < KK; i++) w_q[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
            for (int i = 0; i < KK; i++) w_q[i] <= weights[i*W +: W];
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (col == CNT_W'(N - 1)) begin
              col    <= '0;
              col_ph <= '0;
              if (row == CNT_W'(N - 1)) begin
                row    <= '0;
                row_ph <= '0;
              end else begin
                row    <= row + CNT_W'(1);
                row_ph <= (row >= CNT_W'(K - 1)) ? ph_step(row_ph) : '0;
              end
            end else begin
              col    <= col + CNT_W'(1);
              col_ph <= (col >= CNT_W'(K - 1)) ? ph_step(col_ph) : '0;
            end
            if (last_px) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!vld_p0 && !vld_p1 && !vld_p2) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          frame_done <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    logic [W-1:0] din;
    if (i == 0) begin : g_first
      assign din = bus.in_data;
    end else begin : g_chain
      assign din = lb_out[i-1];
    end
    conv_line_buffer #(.DEPTH(N), .WIDTH(W)) u_lb (
      .clk        (clk),
      .global_rst (global_rst),
      .en         (accept),
      .din        (din),
      .dout       (lb_out[i])
    );
  end

  // Bottom window row takes the live pixel; rows above come from older lines
  always_comb begin
    for (int r = 0; r < K; r++) col_in[r] = '0;
    col_in[K-1] = bus.in_data;
    for (int r = 0; r < K - 1; r++) col_in[r] = lb_out[K-2-r];
  end

  // ---- stage 0: window load on pixel acceptance ----
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_p0[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_p0[r][c] <= win_p0[r][c+1];
        win_p0[r][K-1] <= col_in[r];
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KK; i++) sum_c = sum_c + prod_p1[i];
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
      for (int i = 0; i < KK; i++) prod_p1[i] <= '0;
    end else if (adv) begin
      vld_p0 <= accept && emit;
      // ---- stage 1: K*K products ----
      vld_p1 <= vld_p0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod_p1[r*K+c] <= mul_ext(win_p0[r][c], w_q[r*K+c]);
      // ---- stage 2: reduced sum presented downstream ----
      vld_p2 <= vld_p1;
      if (vld_p1) sum_p2 <= sum_c;
    end
  end

endmodule
